fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_pkg.sv | 16 +
 rtl/skid_buf.sv | 54 +++++
 rtl/fifo_drain.sv | 145 ++++++++++++++
 tb/tb_fifo_drain.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain block.
//   state_t        : drain controller states (IDLE / READ / WAIT_LAST)
//   *_DEF          : default DATA_W, MAX_DATA and ADDR_BITS values
package fifo_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int MAX_DATA_DEF  = 16;
    localparam int ADDR_BITS_DEF = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ      = 2'd1,
        WAIT_LAST = 2'd2
    } state_t;

endpackage : fifo_pkg

// File: rtl/skid_buf.sv
// Two-entry in-order valid/ready buffer.
// The writer must only push while occ < 2. Pushes beyond that are ignored.
// The head word holds stable until the sink accepts it.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid/in_data: write side (in_data is captured when in_valid is high)
//   occ             : current number of stored entries (0..2)
//   out_valid/out_ready/out_data : read side handshake
module skid_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic [1:0]   occ,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;

    assign push      = in_valid && (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // NOTE: the two storage words are reset on purpose. out_data is read
    // straight from storage, so this is what makes the stream data read zero
    // during reset. At this depth the reset costs nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule : skid_buf

// File: rtl/fifo_drain.sv
// Drains an external FIFO into a valid/ready stream in bursts.
// A full burst of BURST words starts once the FIFO holds at least BURST words.
// A flush request drains a smaller residue as one short burst.
// The final word of every burst carries m_last.
//   clk, rst_n            : clock, asynchronous active-low reset
//   f_ren/f_rdata/f_count : FIFO pop strobe, head word (same cycle), occupancy
//   f_empty               : FIFO empty flag (not used: f_count decides reads)
//   m_valid/m_ready/m_data/m_last : output stream
//   flush                 : single-cycle request to drain the residue
//   busy                  : controller active or output words still buffered
//   bursts_done           : completed-burst counter, wraps at 16 bits
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_DATA  = MAX_DATA_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int BURST     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 f_ren,
    input  logic [DATA_W-1:0]    f_rdata,
    input  logic [ADDR_BITS:0]   f_count,
    input  logic                 f_empty,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_last,
    input  logic                 flush,
    output logic                 busy,
    output logic [15:0]          bursts_done
);

    localparam int CNT_W = ADDR_BITS + 1;
    // A burst can never be longer than the FIFO is deep.
    localparam int BURST_EFF = (BURST > MAX_DATA) ? MAX_DATA : BURST;
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_EFF);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] issued, issued_nxt;
    logic [CNT_W-1:0] burst_len, burst_len_nxt;
    logic [CNT_W-1:0] issued_inc;
    logic             flush_pend, flush_pend_nxt;
    logic [15:0]      bursts_done_nxt;

    logic [1:0]        buf_occ;
    logic              buf_empty;
    logic              last_word;
    logic [DATA_W:0]   buf_out;

    // The empty flag is redundant with f_count and deliberately ignored.
    logic unused_f_empty;
    assign unused_f_empty = f_empty;

    assign issued_inc = issued + CNT_W'(1);
    assign last_word  = (issued_inc == burst_len);
    assign buf_empty  = (buf_occ == 2'd0);
    assign busy       = (state != IDLE) || !buf_empty;
    assign {m_last, m_data} = buf_out;

    // NOTE: every state and counter register uses non-blocking assignments.
    // All registers then update together from the values they held before
    // the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            issued      <= '0;
            burst_len   <= '0;
            flush_pend  <= 1'b0;
            bursts_done <= '0;
        end else begin
            state       <= state_nxt;
            issued      <= issued_nxt;
            burst_len   <= burst_len_nxt;
            flush_pend  <= flush_pend_nxt;
            bursts_done <= bursts_done_nxt;
        end
    end

    // NOTE: every output of this block is given a default before the case
    // statement. No path can then leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt       = state;
        issued_nxt      = issued;
        burst_len_nxt   = burst_len;
        flush_pend_nxt  = flush_pend;
        bursts_done_nxt = bursts_done;
        f_ren           = 1'b0;

        unique case (state)
            IDLE: begin
                if (f_count >= BURST_C) begin
                    state_nxt     = READ;
                    burst_len_nxt = BURST_C;
                    issued_nxt    = '0;
                end else if (flush_pend && (f_count != '0)) begin
                    state_nxt     = READ;
                    burst_len_nxt = f_count;
                    issued_nxt    = '0;
                end else if (flush_pend && buf_empty) begin
                    // Nothing is left to drain, so the request is satisfied.
                    flush_pend_nxt = 1'b0;
                end
            end
            READ: begin
                // Reads are gated on f_count, never on f_empty. A read while
                // empty would skip the FIFO read pointer.
                if ((issued < burst_len) && (f_count != '0) && (buf_occ != 2'd2)) begin
                    f_ren      = 1'b1;
                    issued_nxt = issued_inc;
                    if (last_word) begin
                        state_nxt = WAIT_LAST;
                    end
                end
            end
            WAIT_LAST: begin
                if (m_valid && m_ready && m_last) begin
                    state_nxt       = IDLE;
                    bursts_done_nxt = bursts_done + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A flush that arrives during a burst is kept until the next IDLE.
        if (flush) begin
            flush_pend_nxt = 1'b1;
        end
    end

    skid_buf #(
        .W (DATA_W + 1)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (f_ren),
        .in_data   ({last_word, f_rdata}),
        .occ       (buf_occ),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (buf_out)
    );

endmodule : fifo_drain

// File: tb/tb_fifo_drain.sv
// Directed testbench for fifo_drain. A small FIFO model drives the read port.
// A monitor on the falling edge records reads, stream handshakes and stalls.
module tb_fifo_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_ren;
    logic [7:0]  f_rdata;
    logic [5:0]  f_count;
    logic        f_empty;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        flush;
    logic        busy;
    logic [15:0] bursts_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_drain #(
        .DATA_W(8), .MAX_DATA(16), .ADDR_BITS(5), .BURST(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_ren       (f_ren),
        .f_rdata     (f_rdata),
        .f_count     (f_count),
        .f_empty     (f_empty),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .flush       (flush),
        .busy        (busy),
        .bursts_done (bursts_done)
    );

    // ---------------- FIFO model (external to the DUT, never reset) -------
    logic [7:0] fmem [16];
    logic [3:0] fhead = 4'd0;
    logic [3:0] ftail = 4'd0;
    logic [5:0] fcnt  = 6'd0;
    logic       push_en;
    logic [7:0] push_data;

    assign f_rdata = fmem[fhead];
    assign f_count = fcnt;
    assign f_empty = (fcnt == 6'd0);

    always @(posedge clk) begin
        if (push_en) begin
            fmem[ftail] <= push_data;
            ftail       <= ftail + 4'd1;
        end
        if (f_ren) fhead <= fhead + 4'd1;
        fcnt <= fcnt + {5'd0, push_en} - {5'd0, f_ren};
    end

    // ---------------- monitor (samples mid-cycle) --------------------------
    int         cyc = 0;
    int         ren_cnt = 0;
    int         hs_cnt = 0;
    int         max_occ = 0;
    int         stall_cnt = 0;
    int         unstable = 0;
    int         ren_empty = 0;
    int         busy_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;
    logic [7:0] out_q [$];
    logic       last_q [$];
    int         ren_cyc [$];
    int         hs_cyc [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (ren_cnt - hs_cnt > max_occ) max_occ <= ren_cnt - hs_cnt;
            if (f_ren) begin
                ren_cnt <= ren_cnt + 1;
                ren_cyc.push_back(cyc);
                if (f_count == 6'd0) ren_empty <= ren_empty + 1;
            end
            if (m_valid && m_ready) begin
                hs_cnt <= hs_cnt + 1;
                out_q.push_back(m_data);
                last_q.push_back(m_last);
                hs_cyc.push_back(cyc);
            end
            if (prev_stall && ((m_data != prev_data) || (m_last != prev_last)))
                unstable <= unstable + 1;
            if (m_valid && !m_ready) stall_cnt <= stall_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        push_en   = 1'b1;
        push_data = w;
        tick();
        push_en   = 1'b0;
    endtask

    // Bounded wait for a given completed-burst count with the block idle.
    task automatic wait_bursts(input string tag, input logic [15:0] target);
        int n = 0;
        while (((bursts_done != target) || busy) && (n < 200)) begin
            tick();
            n++;
        end
        check({tag, "_bursts_done"}, 32'(bursts_done), 32'(target));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Expects n consecutive words first..first+n-1 at out_q[base], with
    // m_last only on the final one.
    task automatic check_burst(input string tag, input int base, input logic [7:0] first, input int n);
        logic [7:0] w;
        check({tag, "_count"}, 32'(out_q.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < out_q.size()) begin
                w = first + 8'(i);
                check($sformatf("%s_data%0d", tag, i), 32'(out_q[base+i]), 32'(w));
                check($sformatf("%s_last%0d", tag, i), 32'(last_q[base+i]), (i == n - 1) ? 32'd1 : 32'd0);
            end
        end
    endtask

    // ---------------- stimulus ---------------------------------------------
    initial begin
        int base;
        int rbase;
        int bbase;
        int n;

        rst_n     = 1'b0;
        m_ready   = 1'b1;
        flush     = 1'b0;
        push_en   = 1'b0;
        push_data = 8'd0;

        #2;
        check("rst_f_ren", 32'(f_ren), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bursts", 32'(bursts_done), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Full burst of 4 with the sink always ready.
        base  = out_q.size();
        rbase = ren_cyc.size();
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        wait_bursts("t1", 16'd1);
        check_burst("t1", base, 8'h10, 4);
        check("t1_reads", 32'(ren_cyc.size() - rbase), 32'd4);
        if (ren_cyc.size() >= rbase + 4 && hs_cyc.size() >= base + 4) begin
            check("t1_ren_back2back", 32'(ren_cyc[rbase+3] - ren_cyc[rbase]), 32'd3);
            check("t1_first_latency", 32'(hs_cyc[base] - ren_cyc[rbase]), 32'd1);
            check("t1_out_back2back", 32'(hs_cyc[base+3] - hs_cyc[base]), 32'd3);
        end

        // Three-word residue: waits for a flush, then drains as a short burst.
        base  = out_q.size();
        rbase = ren_cyc.size();
        for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
        repeat (10) tick();
        check("t2_no_read_before_flush", 32'(ren_cyc.size() - rbase), 32'd0);
        check("t2_idle_before_flush", 32'(busy), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_bursts("t2", 16'd2);
        check_burst("t2", base, 8'hA0, 3);

        // Burst of 4 with the sink stalled for 5 cycles after the first word.
        base = out_q.size();
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
        n = 0;
        while ((out_q.size() < base + 1) && (n < 50)) begin
            tick();
            n++;
        end
        check("t3_first_word_seen", 32'(out_q.size() - base), 32'd1);
        m_ready = 1'b0;
        repeat (5) tick();
        m_ready = 1'b1;
        wait_bursts("t3", 16'd3);
        check_burst("t3", base, 8'h30, 4);
        check("t3_max_outstanding", 32'(max_occ), 32'd2);
        check("t3_stall_cycles", 32'(stall_cnt), 32'd5);
        check("t3_stable_while_stalled", 32'(unstable), 32'd0);

        // Flush on an empty FIFO does nothing and does not linger.
        rbase = ren_cyc.size();
        bbase = busy_cnt;
        base  = out_q.size();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) tick();
        check("t4_no_busy", 32'(busy_cnt - bbase), 32'd0);
        push(8'h55);
        repeat (10) tick();
        check("t4_single_word_not_drained", 32'(ren_cyc.size() - rbase), 32'd0);
        check("t4_no_output", 32'(out_q.size() - base), 32'd0);

        // Reset after 2 of 4 reads. The FIFO holds 0x55,0x60,0x61,0x62.
        m_ready = 1'b0;
        base  = out_q.size();
        rbase = ren_cyc.size();
        for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
        n = 0;
        while ((ren_cyc.size() < rbase + 2) && (n < 50)) begin
            tick();
            n++;
        end
        check("t5_two_reads", 32'(ren_cyc.size() - rbase), 32'd2);
        check("t5_busy_before_reset", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_f_ren", 32'(f_ren), 32'd0);
        check("t5_rst_m_valid", 32'(m_valid), 32'd0);
        check("t5_rst_m_last", 32'(m_last), 32'd0);
        check("t5_rst_m_data", 32'(m_data), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_bursts", 32'(bursts_done), 32'd0);
        check("t5_no_partial_output", 32'(out_q.size() - base), 32'd0);
        repeat (2) tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        tick();
        // 0x61,0x62 remain. Two more words make a full burst.
        push(8'h63);
        push(8'h64);
        wait_bursts("t5", 16'd1);
        check_burst("t5", base, 8'h61, 4);

        check("never_read_empty", 32'(ren_empty), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fifo_drain
